// File: rtl/ram_hub_mc.sv
// Multi-channel HyperRAM hub: arbitrates NCH host channels onto a single PHY
// command/data port, steers write/read beats and aborts stalled bursts.
module ram_hub_mc #(
    parameter int NCH = 4,
    parameter int AW  = 32,
    parameter int DW  = 16,
    parameter int BLW = 4,
    parameter int TMO = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       host_req,
    input  logic [NCH-1:0]       host_rwn,
    input  logic [NCH*AW-1:0]    host_addr,
    input  logic [NCH*BLW-1:0]   host_len,
    output logic [NCH-1:0]       host_ack,
    input  logic [NCH*DW-1:0]    host_txd,
    input  logic [NCH*2-1:0]     host_txm,
    output logic [NCH-1:0]       host_txd_ack,
    output logic [DW-1:0]        host_rxd,
    output logic [NCH-1:0]       host_rxd_vld,
    output logic [NCH-1:0]       host_err,
    input  logic                 prio_fixed,
    input  logic                 hub_disable,
    output logic                 phy_req,
    output logic                 phy_rwn,
    output logic [AW-1:0]        phy_addr,
    output logic [BLW-1:0]       phy_len,
    input  logic                 phy_ack,
    output logic [DW-1:0]        phy_txd,
    output logic [1:0]           phy_txm,
    input  logic                 phy_txd_ack,
    input  logic [DW-1:0]        phy_rxd,
    input  logic                 phy_rxd_vld,
    output logic                 phy_fin,
    output logic                 busy
);

    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WDW = $clog2(TMO + 1);

    localparam logic [BLW:0]   CNT_ONE = (BLW + 1)'(1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TMO);
    localparam logic [PW-1:0]  PW_ONE  = PW'(1);
    localparam logic [PW-1:0]  CH_LAST = PW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [PW-1:0]  g_r;
    logic [PW-1:0]  ptr_r;
    logic           rwn_r;
    logic [AW-1:0]  addr_r;
    logic [BLW-1:0] len_r;
    logic [BLW:0]   cnt_r;
    logic [WDW-1:0] wd_r;

    logic [PW-1:0]  pick_s;
    logic [PW-1:0]  ptr_next_s;
    logic           go_s;
    logic           beat_s;
    logic           last_s;
    logic           tmo_s;
    logic           active_s;

    // First requesting channel at or after 'start' (wrapping); 'fixed' searches from 0.
    function automatic logic [PW-1:0] pick(input logic [NCH-1:0] req,
                                           input logic [PW-1:0]  start,
                                           input logic           fixed);
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic [PW-1:0] res;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sum = (fixed ? {(PW + 1){1'b0}} : {1'b0, start}) + (PW + 1)'(i);
            sum = (sum >= (PW + 1)'(NCH)) ? (sum - (PW + 1)'(NCH)) : sum;
            idx = sum[PW-1:0];
            res   = (!found && req[idx]) ? idx : res;
            found = found | req[idx];
        end
        return res;
    endfunction

    assign pick_s     = pick(host_req, ptr_r, prio_fixed);
    assign go_s       = (state_r == IDLE) && !hub_disable && (|host_req);
    assign last_s     = (cnt_r == ({1'b0, len_r} + CNT_ONE));
    assign tmo_s      = (wd_r == WD_MAX);
    // Beats are only forwarded while the burst is still open (not in the fin/abort cycle).
    assign active_s   = (state_r == DATA) && !last_s && !tmo_s;
    assign beat_s     = rwn_r ? phy_rxd_vld : phy_txd_ack;
    assign ptr_next_s = (g_r == CH_LAST) ? {PW{1'b0}} : (g_r + PW_ONE);

    assign phy_rwn  = rwn_r;
    assign phy_addr = addr_r;
    assign phy_len  = len_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    state_s = CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (phy_ack) begin
                    state_s = DATA;
                end else begin
                    state_s = CMD;
                end
            end
            DATA: begin
                if (last_s || tmo_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DATA;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Grant capture, beat counter, watchdog and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_r    <= '0;
            ptr_r  <= '0;
            rwn_r  <= 1'b0;
            addr_r <= '0;
            len_r  <= '0;
            cnt_r  <= '0;
            wd_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        g_r    <= pick_s;
                        rwn_r  <= host_rwn[pick_s];
                        addr_r <= host_addr[pick_s*AW +: AW];
                        len_r  <= host_len[pick_s*BLW +: BLW];
                    end
                end
                CMD: begin
                    if (phy_ack) begin
                        cnt_r <= '0;
                        wd_r  <= '0;
                    end
                end
                DATA: begin
                    if (active_s && beat_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        wd_r  <= '0;
                    end else if (!tmo_s) begin
                        wd_r <= wd_r + WD_ONE;
                    end
                end
                DONE: begin
                    if (!prio_fixed) begin
                        ptr_r <= ptr_next_s;
                    end
                end
                default: begin
                    cnt_r <= '0;
                    wd_r  <= '0;
                end
            endcase
        end
    end

    // FSM outputs and data steering to/from the granted channel
    always_comb begin
        phy_req      = 1'b0;
        phy_fin      = 1'b0;
        phy_txd      = '0;
        phy_txm      = 2'b00;
        host_ack     = '0;
        host_err     = '0;
        host_txd_ack = '0;
        host_rxd_vld = '0;
        host_rxd     = '0;
        busy         = 1'b1;
        case (state_r)
            IDLE: busy = 1'b0;
            CMD: begin
                phy_req       = 1'b1;
                host_ack[g_r] = phy_ack;
            end
            DATA: begin
                if (last_s || tmo_s) begin
                    // A completed burst wins over a watchdog expiry in the same cycle.
                    phy_fin       = 1'b1;
                    host_err[g_r] = tmo_s && !last_s;
                end else if (rwn_r) begin
                    host_rxd          = phy_rxd;
                    host_rxd_vld[g_r] = phy_rxd_vld;
                end else begin
                    phy_txd           = host_txd[g_r*DW +: DW];
                    phy_txm           = host_txm[g_r*2 +: 2];
                    host_txd_ack[g_r] = phy_txd_ack;
                end
            end
            DONE:    busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

endmodule
